dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// One master's request/response channel into the dmem arbiter.
// The master drives the request fields; the arbiter returns grant and load data.
interface dmem_arbiter_if;
    logic        req;
    logic        lock;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, lock, addr, we, wdata, mode,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, addr, we, wdata, mode,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port, with a bounded
// burst lock and routing of the one-cycle-latency load data back to its owner.
module dmem_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter bit M0_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmem_arbiter_if.slave        m0,
    dmem_arbiter_if.slave        m1,
    output logic [31:0]          dmem_address,
    output logic                 dmem_enable,
    output logic [31:0]          dmem_write_data,
    output logic                 dmem_write_enable,
    output logic [2:0]           dmem_write_mode,
    output logic                 dmem_read_enable,
    output logic [2:0]           dmem_read_mode,
    input  logic [31:0]          dmem_read_data,
    input  logic                 dmem_wait
);

    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  mode  [2];

    assign req  = {m1.req,  m0.req};
    assign lock = {m1.lock, m0.lock};
    assign we   = {m1.we,   m0.we};
    assign addr[0]  = m0.addr;
    assign addr[1]  = m1.addr;
    assign wdata[0] = m0.wdata;
    assign wdata[1] = m1.wdata;
    assign mode[0]  = m0.mode;
    assign mode[1]  = m1.mode;

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rvalid[0];
    assign m1.rvalid = rvalid[1];
    assign m0.rdata  = dmem_read_data;
    assign m1.rdata  = dmem_read_data;

    // prio_m0_reg=1 means M0 wins the next tie.
    logic       prio_m0_reg,    prio_m0_next;
    logic       lock_act_reg,   lock_act_next;
    logic       lock_owner_reg, lock_owner_next;
    logic [7:0] lock_cnt_reg,   lock_cnt_next;
    logic       pend_reg,       pend_next;
    logic       pend_id_reg,    pend_id_next;

    logic winner;
    logic any_req;
    logic accept;
    logic at_max;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio_m0_reg    <= M0_FIRST;
            lock_act_reg   <= 1'b0;
            lock_owner_reg <= 1'b0;
            lock_cnt_reg   <= 8'd0;
            pend_reg       <= 1'b0;
            pend_id_reg    <= 1'b0;
        end else begin
            prio_m0_reg    <= prio_m0_next;
            lock_act_reg   <= lock_act_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            pend_reg       <= pend_next;
            pend_id_reg    <= pend_id_next;
        end
    end

    always_comb begin
        winner  = 1'b0;
        any_req = 1'b0;
        at_max  = (lock_cnt_reg == LOCK_MAX);
        if (lock_act_reg && req[lock_owner_reg]) begin
            any_req = 1'b1;
            // A saturated lock yields exactly one transfer to a waiting master.
            if (at_max && req[~lock_owner_reg])
                winner = ~lock_owner_reg;
            else
                winner = lock_owner_reg;
        end else if (req[0] ^ req[1]) begin
            any_req = 1'b1;
            winner  = req[1];
        end else if (req[0] && req[1]) begin
            any_req = 1'b1;
            winner  = !prio_m0_reg;
        end
        accept = any_req && !dmem_wait && reset_n;
    end

    always_comb begin
        prio_m0_next    = prio_m0_reg;
        lock_act_next   = lock_act_reg;
        lock_owner_next = lock_owner_reg;
        lock_cnt_next   = lock_cnt_reg;
        pend_next       = accept && !we[winner];
        pend_id_next    = winner;
        if (!dmem_wait) begin
            if (accept) begin
                prio_m0_next = winner;
                if (lock[winner]) begin
                    lock_act_next   = 1'b1;
                    lock_owner_next = winner;
                    if (lock_act_reg && lock_owner_reg == winner)
                        lock_cnt_next = at_max ? lock_cnt_reg : lock_cnt_reg + 8'd1;
                    else
                        lock_cnt_next = 8'd1;
                end else begin
                    lock_act_next = 1'b0;
                    lock_cnt_next = 8'd0;
                end
            end else begin
                // No accept without a stall means nobody, the owner included, is requesting.
                lock_act_next = 1'b0;
                lock_cnt_next = 8'd0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign gnt[gi]    = accept && (winner == 1'(gi));
            assign rvalid[gi] = reset_n && pend_reg && (pend_id_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        dmem_enable       = 1'b0;
        dmem_write_enable = 1'b0;
        dmem_read_enable  = 1'b0;
        dmem_address      = 32'd0;
        dmem_write_data   = 32'd0;
        dmem_write_mode   = 3'd0;
        dmem_read_mode    = 3'd0;
        if (accept) begin
            dmem_enable       = 1'b1;
            dmem_write_enable = we[winner];
            dmem_read_enable  = !we[winner];
            dmem_address      = addr[winner];
            dmem_write_data   = wdata[winner];
            dmem_write_mode   = mode[winner];
            dmem_read_mode    = mode[winner];
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario and randomized bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if m0_bus ();
    dmem_arbiter_if m1_bus ();

    logic [31:0] dmem_address, dmem_write_data, dmem_read_data;
    logic        dmem_enable, dmem_write_enable, dmem_read_enable, dmem_wait;
    logic [2:0]  dmem_write_mode, dmem_read_mode;

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .M0_FIRST(1'b1)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .m0                (m0_bus),
        .m1                (m1_bus),
        .dmem_address      (dmem_address),
        .dmem_enable       (dmem_enable),
        .dmem_write_data   (dmem_write_data),
        .dmem_write_enable (dmem_write_enable),
        .dmem_write_mode   (dmem_write_mode),
        .dmem_read_enable  (dmem_read_enable),
        .dmem_read_mode    (dmem_read_mode),
        .dmem_read_data    (dmem_read_data),
        .dmem_wait         (dmem_wait)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: who wins a tie, the lock, and the outstanding load.
    bit tie_m0  = 1'b1;
    bit m_act   = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;
    int m_pid   = 0;

    int          e_win;
    bit          e_rv0, e_rv1;
    logic [76:0] e_vec;

    task automatic model_eval();
        bit rq[2];
        logic [31:0] fa, fd;
        logic [2:0] fm;
        logic fwe, en;
        rq[0] = m0_bus.req;
        rq[1] = m1_bus.req;
        e_win = -1;
        if (reset_n && !dmem_wait) begin
            if (m_act && rq[m_owner])
                e_win = (m_cnt == MAX_LOCK && rq[1 - m_owner]) ? 1 - m_owner : m_owner;
            else if (rq[0] && rq[1])
                e_win = tie_m0 ? 0 : 1;
            else if (rq[0])
                e_win = 0;
            else if (rq[1])
                e_win = 1;
        end
        if (e_win == 1) begin
            fa = m1_bus.addr; fd = m1_bus.wdata; fm = m1_bus.mode; fwe = m1_bus.we;
        end else begin
            fa = m0_bus.addr; fd = m0_bus.wdata; fm = m0_bus.mode; fwe = m0_bus.we;
        end
        en    = (e_win >= 0);
        e_rv0 = reset_n && m_pend && m_pid == 0;
        e_rv1 = reset_n && m_pend && m_pid == 1;
        e_vec = {e_win == 0, e_win == 1, e_rv0, e_rv1, en, en & fwe, en & ~fwe,
                 en ? fm : 3'd0, en ? fm : 3'd0, en ? fa : 32'd0, en ? fd : 32'd0};
    endtask

    task automatic model_commit();
        bit lk, wr;
        if (!reset_n) begin
            tie_m0 = 1'b1; m_act = 1'b0; m_cnt = 0; m_pend = 1'b0;
        end else if (dmem_wait) begin
            m_pend = 1'b0;
        end else if (e_win >= 0) begin
            lk = (e_win == 1) ? m1_bus.lock : m0_bus.lock;
            wr = (e_win == 1) ? m1_bus.we : m0_bus.we;
            tie_m0 = (e_win == 1);
            if (lk) begin
                if (m_act && m_owner == e_win)
                    m_cnt = (m_cnt < MAX_LOCK) ? m_cnt + 1 : MAX_LOCK;
                else
                    m_cnt = 1;
                m_act = 1'b1;
                m_owner = e_win;
            end else begin
                m_act = 1'b0;
                m_cnt = 0;
            end
            m_pend = !wr;
            m_pid = e_win;
            $display("txn m%0d we=%0d addr=%h", e_win, wr, dmem_address);
        end else begin
            m_act = 1'b0; m_cnt = 0; m_pend = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input int id, input bit rq, input bit lk, input bit w,
                         input logic [31:0] a, input logic [2:0] md);
        if (id == 0) begin
            m0_bus.req = rq; m0_bus.lock = lk; m0_bus.we = w; m0_bus.addr = a;
            m0_bus.wdata = $urandom; m0_bus.mode = md;
        end else begin
            m1_bus.req = rq; m1_bus.lock = lk; m1_bus.we = w; m1_bus.addr = a;
            m1_bus.wdata = $urandom; m1_bus.mode = md;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 1, 0, 1, 32'h8000_0010, 3'd2);
        drive(1, 1, 0, 1, 32'h8000_0020, 3'd2);
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if ({m0_bus.gnt, m1_bus.gnt, dmem_enable, m0_bus.rvalid, m1_bus.rvalid} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d got gnt=%b%b en=%b rv=%b%b want all 0", i,
                         m0_bus.gnt, m1_bus.gnt, dmem_enable, m0_bus.rvalid, m1_bus.rvalid);
            end
            advance();
        end
        reset_n = 1'b1;
        settle();
        n_cmp++;
        if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_first_tie got gnt=%b%b want 10", m0_bus.gnt, m1_bus.gnt);
        end
        advance();
        settle();
        n_cmp++;
        if ({m0_bus.gnt, m1_bus.gnt} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_second_tie got gnt=%b%b want 01", m0_bus.gnt, m1_bus.gnt);
        end
        advance();
        drive(0, 0, 0, 0, 32'd0, 3'd0);
        drive(1, 0, 0, 0, 32'd0, 3'd0);
    endtask

    task automatic test_single_load();
        drive(0, 1, 0, 0, 32'h8000_0004, 3'd2);
        settle();
        n_cmp++;
        if ({m0_bus.gnt, dmem_read_enable, dmem_write_enable, dmem_read_mode} !== 6'b110_010
            || dmem_address !== 32'h8000_0004) begin
            n_bad++;
            $display("FAIL load_issue got gnt=%b re=%b we=%b rmode=%0d addr=%h want 1 1 0 2 80000004",
                     m0_bus.gnt, dmem_read_enable, dmem_write_enable, dmem_read_mode, dmem_address);
        end
        advance();
        drive(0, 0, 0, 0, 32'd0, 3'd0);
        dmem_read_data = 32'hDEAD_BEEF;
        settle();
        n_cmp++;
        if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b10 || m0_bus.rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL load_return got rv=%b%b rdata=%h want rv=10 rdata=deadbeef",
                     m0_bus.rvalid, m1_bus.rvalid, m0_bus.rdata);
        end
        advance();
        settle();
        n_cmp++;
        if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin
            n_bad++;
            $display("FAIL load_pulse got rv=%b%b want 00", m0_bus.rvalid, m1_bus.rvalid);
        end
        advance();
    endtask

    task automatic test_round_robin();
        int prev = -1;
        int cur;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 1, 32'h8000_1000 + 32'(4 * i), 3'd2);
            drive(1, 1, 0, 1, 32'h7000_0000 + 32'(4 * i), 3'd1);
            settle();
            cur = m1_bus.gnt ? 1 : 0;
            n_cmp++;
            if ((m0_bus.gnt ^ m1_bus.gnt) !== 1'b1 || (prev >= 0 && cur == prev)
                || cur != e_win) begin
                n_bad++;
                $display("FAIL round_robin cyc%0d got gnt=%b%b prev=m%0d want m%0d",
                         i, m0_bus.gnt, m1_bus.gnt, prev, e_win);
            end
            prev = cur;
            advance();
        end
    endtask

    task automatic test_lock();
        bit exp_m1 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        drive(0, 1, 0, 1, 32'h8000_0100, 3'd2);
        drive(1, 0, 0, 1, 32'h0, 3'd0);
        settle();
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 1, 32'h8000_0200, 3'd2);
            drive(1, 1, 1, 1, 32'h8000_0300 + 32'(4 * i), 3'd2);
            settle();
            n_cmp++;
            if (m1_bus.gnt !== exp_m1[i] || m0_bus.gnt !== !exp_m1[i]) begin
                n_bad++;
                $display("FAIL lock_sat cyc%0d got gnt=%b%b want m%0d", i,
                         m0_bus.gnt, m1_bus.gnt, exp_m1[i] ? 1 : 0);
            end
            advance();
        end
        drive(0, 0, 0, 0, 32'd0, 3'd0);
        drive(1, 0, 0, 0, 32'd0, 3'd0);
        settle();
        advance();
    endtask

    task automatic test_wait();
        int w;
        bit g [2];
        bit rv [2];
        drive(0, 1, 0, 0, 32'h8000_0040, 3'd2);
        drive(1, 1, 0, 0, 32'h0000_0080, 3'd0);
        dmem_wait = 1'b0;
        settle();
        w = e_win;
        g[0] = m0_bus.gnt; g[1] = m1_bus.gnt;
        n_cmp++;
        if (w < 0 || g[w] !== 1'b1 || g[1 - w] !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_pre got gnt=%b%b want m%0d", g[0], g[1], w);
        end
        advance();
        dmem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_read_data = $urandom;
            settle();
            rv[0] = m0_bus.rvalid; rv[1] = m1_bus.rvalid;
            n_cmp++;
            if ({m0_bus.gnt, m1_bus.gnt, dmem_enable} !== 3'b000
                || rv[w] !== (i == 0) || rv[1 - w] !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_stall cyc%0d got gnt=%b%b en=%b rv=%b%b want gnt=00 rv_m%0d=%0d",
                         i, m0_bus.gnt, m1_bus.gnt, dmem_enable, rv[0], rv[1], w, i == 0);
            end
            advance();
        end
        dmem_wait = 1'b0;
        settle();
        g[0] = m0_bus.gnt; g[1] = m1_bus.gnt;
        n_cmp++;
        if (g[1 - w] !== 1'b1 || g[w] !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_resume got gnt=%b%b want m%0d", g[0], g[1], 1 - w);
        end
        advance();
        drive(0, 0, 0, 0, 32'd0, 3'd0);
        drive(1, 0, 0, 0, 32'd0, 3'd0);
        settle();
        advance();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 1, 0, 0, 32'h8000_0800, 3'd2);
        settle();
        n_cmp++;
        if (m1_bus.gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_issue got m1_gnt=%b want 1", m1_bus.gnt);
        end
        advance();
        drive(1, 0, 0, 0, 32'd0, 3'd0);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin
                n_bad++;
                $display("FAIL midreset_drop cyc%0d got rv=%b%b want 00", i,
                         m0_bus.rvalid, m1_bus.rvalid);
            end
            advance();
            reset_n = 1'b1;
        end
    endtask

    task automatic test_random();
        logic [76:0] obs;
        for (int i = 0; i < 500; i++) begin
            for (int m = 0; m < 2; m++)
                drive(m, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                      {$urandom_range(0, 2) == 0 ? 4'h0 : ($urandom_range(0, 1) ? 4'h7 : 4'h8),
                       12'h000, 16'($urandom)}, 3'($urandom_range(0, 2)));
            dmem_wait = $urandom_range(0, 9) < 2;
            reset_n = $urandom_range(0, 49) != 0;
            dmem_read_data = $urandom;
            settle();
            obs = {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid, dmem_enable,
                   dmem_write_enable, dmem_read_enable, dmem_write_mode, dmem_read_mode,
                   dmem_address, dmem_write_data};
            n_cmp++;
            if (obs !== e_vec) begin
                n_bad++;
                $display("FAIL random cyc%0d got %h want %h", i, obs, e_vec);
            end
            n_cmp++;
            if (m0_bus.rdata !== dmem_read_data || m1_bus.rdata !== dmem_read_data) begin
                n_bad++;
                $display("FAIL rdata_pass cyc%0d got %h/%h want %h", i,
                         m0_bus.rdata, m1_bus.rdata, dmem_read_data);
            end
            advance();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        dmem_wait = 1'b0;
        dmem_read_data = 32'd0;
        drive(0, 0, 0, 0, 32'd0, 3'd0);
        drive(1, 0, 0, 0, 32'd0, 3'd0);
        test_reset();
        test_single_load();
        test_round_robin();
        test_lock();
        test_wait();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish within 200000 want finish");
        $fatal(1, "timeout");
    end

endmodule
